// File: rtl/spi_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : spi_arb -- round-robin arbiter sharing one SPI flash among three
//          masters (erase / program / read), with watchdog and cs_n guard time.
// Rev    : 1.0
// ============================================================================
module spi_arb #(
   parameter int          N_REQ   = 3,
   parameter logic [7:0]  TCSH    = 8'd5,
   parameter logic [19:0] TIMEOUT = 20'd1000000
) (
   input  logic             sclk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] done,
   input  logic [N_REQ-1:0] cs_n_i,
   input  logic [N_REQ-1:0] sck_i,
   input  logic [N_REQ-1:0] sdi_i,
   output logic [N_REQ-1:0] gnt,
   output logic             cs_n,
   output logic             sck,
   output logic             sdi,
   output logic             busy,
   output logic             err
);

   localparam int IDX_W = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GUARD = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [IDX_W-1:0] last_idx;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] cand;
   logic             win_valid;
   logic             grant_start;
   logic             release_gnt;
   logic             timeout_hit;
   logic [19:0]      wdog;
   logic [7:0]       guard_cnt;

   // Search starts just after the last granted requester and wraps around.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IDX_W'((int'(last_idx) + k) % N_REQ);
         if (!win_valid && req[cand]) begin
            win_valid = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_nx    = state;
      grant_start = 1'b0;
      release_gnt = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (win_valid) begin
               state_nx    = GRANT;
               grant_start = 1'b1;
            end
         end
         GRANT: begin
            // A genuine release beats a coinciding watchdog expiry.
            if (done[last_idx] || !req[last_idx]) begin
               state_nx    = GUARD;
               release_gnt = 1'b1;
            end else if (wdog == TIMEOUT - 20'd1) begin
               state_nx    = GUARD;
               release_gnt = 1'b1;
               timeout_hit = 1'b1;
            end
         end
         GUARD: begin
            if (guard_cnt == TCSH - 8'd1) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         gnt       <= '0;
         cs_n      <= 1'b1;
         sck       <= 1'b0;
         sdi       <= 1'b0;
         err       <= 1'b0;
         wdog      <= '0;
         guard_cnt <= '0;
         last_idx  <= IDX_W'(2);
      end else begin
         err <= timeout_hit;

         if (grant_start) begin
            gnt      <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
            last_idx <= win_idx;
         end else if (release_gnt) begin
            gnt <= '0;
         end

         if (grant_start) begin
            wdog <= '0;
         end else if (state == GRANT) begin
            wdog <= wdog + 20'd1;
         end

         // The flash only sees the owner's pins while the grant is held.
         if (state == GRANT && !release_gnt) begin
            cs_n <= cs_n_i[last_idx];
            sck  <= sck_i[last_idx];
            sdi  <= sdi_i[last_idx];
         end else begin
            cs_n <= 1'b1;
            sck  <= 1'b0;
            sdi  <= 1'b0;
         end

         if (state == GUARD) begin
            guard_cnt <= guard_cnt + 8'd1;
         end else begin
            guard_cnt <= '0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_spi_arb -- self-checking bench for spi_arb (TCSH=5, TIMEOUT=16).
// Rev    : 1.0
// ============================================================================
module tb_spi_arb;

   logic        sclk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [2:0]  done;
   logic [2:0]  cs_n_i;
   logic [2:0]  sck_i;
   logic [2:0]  sdi_i;
   logic [2:0]  gnt;
   logic        cs_n;
   logic        sck;
   logic        sdi;
   logic        busy;
   logic        err;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [2:0]  exp_q[$];
   logic [2:0]  prev_gnt = 3'b000;

   typedef struct {
      logic [2:0] req_mask;
      logic [2:0] exp_gnt;
      int         hold;
   } vec_t;

   vec_t vecs[7];

   spi_arb #(
      .N_REQ   (3),
      .TCSH    (8'd5),
      .TIMEOUT (20'd16)
   ) dut (
      .sclk   (sclk),
      .rst    (rst),
      .req    (req),
      .done   (done),
      .cs_n_i (cs_n_i),
      .sck_i  (sck_i),
      .sdi_i  (sdi_i),
      .gnt    (gnt),
      .cs_n   (cs_n),
      .sck    (sck),
      .sdi    (sdi),
      .busy   (busy),
      .err    (err)
   );

   always #5 sclk = ~sclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int oh_idx(input logic [2:0] v);
      case (v)
         3'b001:  return 0;
         3'b010:  return 1;
         default: return 2;
      endcase
   endfunction

   // Scoreboard: every rising grant must match the oldest expected grant.
   always @(negedge sclk) begin
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      if (prev_gnt == 3'b000 && gnt != 3'b000) begin
         if (exp_q.size() == 0) begin
            chk("gnt_unexpected", 32'(gnt), 32'd0);
         end else begin
            chk("gnt_order", 32'(gnt), 32'(exp_q.pop_front()));
         end
      end
      prev_gnt = gnt;
   end

   task automatic wait_gnt(output int w);
      w = 0;
      while (gnt == 3'b000 && w < 40) begin
         @(negedge sclk);
         w++;
      end
      if (gnt == 3'b000) chk("gnt_wait_bound", 32'(w), 32'd0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 40) begin
         @(negedge sclk);
         n++;
      end
      chk("idle_wait_bound", 32'(busy), 32'd0);
   endtask

   initial begin
      int         w;
      int         gi;
      int         n;
      logic [2:0] last_pins;

      vecs[0] = '{req_mask: 3'b001, exp_gnt: 3'b001, hold: 4};
      vecs[1] = '{req_mask: 3'b111, exp_gnt: 3'b010, hold: 6};
      vecs[2] = '{req_mask: 3'b101, exp_gnt: 3'b100, hold: 3};
      vecs[3] = '{req_mask: 3'b011, exp_gnt: 3'b001, hold: 5};
      vecs[4] = '{req_mask: 3'b100, exp_gnt: 3'b100, hold: 2};
      vecs[5] = '{req_mask: 3'b110, exp_gnt: 3'b010, hold: 4};
      vecs[6] = '{req_mask: 3'b101, exp_gnt: 3'b100, hold: 3};

      rst    = 1'b1;
      req    = 3'b000;
      done   = 3'b000;
      cs_n_i = 3'b111;
      sck_i  = 3'b000;
      sdi_i  = 3'b000;
      repeat (3) @(negedge sclk);
      chk("rst_gnt",  32'(gnt),  32'd0);
      chk("rst_cs_n", 32'(cs_n), 32'd1);
      chk("rst_sck",  32'(sck),  32'd0);
      chk("rst_sdi",  32'(sdi),  32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err",  32'(err),  32'd0);
      rst = 1'b0;
      @(negedge sclk);

      // Table-driven transactions: arbitration, pin pass-through, release, guard.
      for (int i = 0; i < 7; i++) begin
         req = vecs[i].req_mask;
         exp_q.push_back(vecs[i].exp_gnt);
         wait_gnt(w);
         chk("gnt_latency", 32'(w), 32'd1);
         chk("pins_first_cycle", 32'({cs_n, sck, sdi}), 32'b100);
         gi = oh_idx(vecs[i].exp_gnt);
         for (int k = 0; k < vecs[i].hold; k++) begin
            {cs_n_i, sck_i, sdi_i} = 9'($urandom);
            done = 3'($urandom) & ~vecs[i].exp_gnt;
            req  = vecs[i].req_mask | (3'($urandom) & ~vecs[i].exp_gnt);
            last_pins = {cs_n_i[gi], sck_i[gi], sdi_i[gi]};
            @(negedge sclk);
            chk("pins_pipe", 32'({cs_n, sck, sdi}), 32'(last_pins));
            chk("gnt_held", 32'(gnt), 32'(vecs[i].exp_gnt));
         end
         done = vecs[i].exp_gnt;
         req  = 3'b000;
         @(negedge sclk);
         done = 3'b000;
         chk("rel_gnt", 32'(gnt), 32'd0);
         chk("rel_pins", 32'({cs_n, sck, sdi}), 32'b100);
         n = 0;
         while (busy && n < 20) begin
            n++;
            @(negedge sclk);
         end
         chk("guard_len", 32'(n), 32'd5);
      end

      // Round robin with all requests held: 0,1,2,0 and guard gap between grants.
      req = 3'b111;
      exp_q.push_back(3'b001);
      exp_q.push_back(3'b010);
      exp_q.push_back(3'b100);
      exp_q.push_back(3'b001);
      wait_gnt(w);
      chk("rr_first_latency", 32'(w), 32'd1);
      for (int r = 0; r < 4; r++) begin
         repeat (9) @(negedge sclk);
         done = gnt;
         if (r == 3) req = 3'b000;
         @(negedge sclk);
         done = 3'b000;
         if (r < 3) begin
            wait_gnt(w);
            chk("rr_regrant_gap", 32'(w), 32'd6);
         end
      end
      wait_idle();

      // Watchdog timeout on requester 1, then re-grant after guard.
      req = 3'b010;
      exp_q.push_back(3'b010);
      exp_q.push_back(3'b010);
      wait_gnt(w);
      n = 0;
      for (int k = 1; k <= 15; k++) begin
         @(negedge sclk);
         if (err) n++;
      end
      chk("to_err_early", 32'(n), 32'd0);
      chk("to_gnt_before", 32'(gnt), 32'b010);
      @(negedge sclk);
      chk("to_err_pulse", 32'(err), 32'd1);
      chk("to_gnt_drop", 32'(gnt), 32'd0);
      @(negedge sclk);
      chk("to_err_one_cycle", 32'(err), 32'd0);
      wait_gnt(w);
      chk("to_regrant_gap", 32'(w), 32'd5);
      req = 3'b000;
      @(negedge sclk);
      chk("to_withdraw_gnt", 32'(gnt), 32'd0);
      chk("to_withdraw_err", 32'(err), 32'd0);
      wait_idle();

      // done on the watchdog terminal cycle: normal release, no err.
      req = 3'b100;
      exp_q.push_back(3'b100);
      wait_gnt(w);
      repeat (15) @(negedge sclk);
      done = 3'b100;
      req  = 3'b000;
      @(negedge sclk);
      done = 3'b000;
      chk("coll_err", 32'(err), 32'd0);
      chk("coll_gnt", 32'(gnt), 32'd0);
      @(negedge sclk);
      chk("coll_err_after", 32'(err), 32'd0);
      wait_idle();

      // Foreign done/req ignored; withdraw of req[0] releases; req[1] follows.
      req = 3'b001;
      exp_q.push_back(3'b001);
      wait_gnt(w);
      @(negedge sclk);
      req  = 3'b011;
      done = 3'b010;
      @(negedge sclk);
      chk("foreign_done_ignored", 32'(gnt), 32'b001);
      done = 3'b000;
      req  = 3'b010;
      exp_q.push_back(3'b010);
      @(negedge sclk);
      chk("withdraw_gnt", 32'(gnt), 32'd0);
      chk("withdraw_busy", 32'(busy), 32'd1);
      wait_gnt(w);
      chk("withdraw_regrant_gap", 32'(w), 32'd6);
      done = 3'b010;
      req  = 3'b000;
      @(negedge sclk);
      done = 3'b000;
      wait_idle();

      // Reset in the middle of a grant to requester 2.
      req = 3'b100;
      exp_q.push_back(3'b100);
      wait_gnt(w);
      cs_n_i = 3'b000;
      sck_i  = 3'b111;
      sdi_i  = 3'b111;
      repeat (2) @(negedge sclk);
      chk("mid_pins", 32'({cs_n, sck, sdi}), 32'b011);
      rst = 1'b1;
      req = 3'b110;
      @(negedge sclk);
      chk("mid_rst_gnt", 32'(gnt), 32'd0);
      chk("mid_rst_pins", 32'({cs_n, sck, sdi}), 32'b100);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      exp_q.push_back(3'b010);
      @(negedge sclk);
      chk("post_rst_gnt", 32'(gnt), 32'b010);
      done = 3'b010;
      req  = 3'b000;
      @(negedge sclk);
      done = 3'b000;
      wait_idle();

      repeat (2) @(negedge sclk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_arb.md
SPI_ARB -- requirements
Module: spi_arb

Interface
REQ-001 Parameter: N_REQ, 3, number of SPI requesters, fixed at 3 (0=sector erase, 1=page program, 2=read).
REQ-002 Parameter: TCSH, 5, minimum deselect (cs_n high) cycles between transactions, range 1-255.
REQ-003 Parameter: TIMEOUT, 20'd1000000, maximum grant length in cycles, range 2 to 2^20-1.
REQ-004 sclk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 req  input  3  per-requester request level, held high until done or withdrawn.
REQ-007 done  input  3  per-requester one-cycle transaction-complete pulse.
REQ-008 cs_n_i  input  3  per-requester chip select (bit i = requester i).
REQ-009 sck_i  input  3  per-requester SPI clock.
REQ-010 sdi_i  input  3  per-requester serial data to flash.
REQ-011 gnt  output  3  one-hot grant, registered.
REQ-012 cs_n  output  1  flash chip select, registered.
REQ-013 sck  output  1  flash SPI clock, registered.
REQ-014 sdi  output  1  flash serial data in, registered.
REQ-015 busy  output  1  high whenever the state is not IDLE.
REQ-016 err  output  1  one-cycle pulse on grant timeout.

Function
REQ-017 FSM states: IDLE, GRANT, GUARD; busy = (state != IDLE).
REQ-018 IDLE: if any req bit is high at edge N, the block SHALL assert a one-hot gnt to the winner from edge N (visible in cycle N+1) and enter GRANT.
REQ-019 Arbitration: round-robin; search order starts at (last granted index + 1) mod 3; after reset, last granted = 2, so requester 0 has first priority.
REQ-020 gnt SHALL be one-hot or zero at all times; never more than one bit high.
REQ-021 GRANT: outputs cs_n/sck/sdi SHALL equal the granted requester's cs_n_i/sck_i/sdi_i delayed by exactly one register stage.
REQ-022 When not in GRANT, outputs SHALL be cs_n=1, sck=0, sdi=0.
REQ-023 GRANT exits on the first of: done[g] high, req[g] low, or watchdog expiry; on exit gnt clears at the same edge, cs_n forced 1 from the next cycle, and the state moves to GUARD.
REQ-024 done or req changes from non-granted requesters SHALL be ignored while in GRANT.
REQ-025 Watchdog: a 20-bit counter clears on entry to GRANT and increments each GRANT cycle; when it reaches TIMEOUT-1 without a release condition, exit GRANT and pulse err for one cycle.
REQ-026 If done[g] and watchdog expiry coincide, done wins: no err pulse.
REQ-027 GUARD: stay exactly TCSH cycles with cs_n=1, then go to IDLE; requests are sampled but not granted during GUARD.
REQ-028 A request held continuously through GUARD SHALL be granted on the IDLE cycle immediately following GUARD, with no extra idle cycle.
REQ-029 last granted index updates on entry to GRANT only.

Reset
REQ-030 With rst high at an edge: state=IDLE, gnt=0, cs_n=1, sck=0, sdi=0, busy=0, err=0, watchdog=0, guard counter=0, last granted=2.
REQ-031 A reset asserted mid-GRANT SHALL drop gnt and raise cs_n at that same edge, with no GUARD interval.
REQ-032 A req held through a reset release SHALL be arbitrated on the first edge after rst goes low.

Verification
REQ-033 Single request: req=3'b001 at cycle 0 -> gnt=3'b001 at cycle 1; cs_n follows cs_n_i[0] with 1-cycle lag; done[0] pulse -> gnt=0 next cycle, cs_n=1 for 5 cycles, busy low after.
REQ-034 Round robin: req=3'b111 held, each granted requester pulses done after 10 cycles -> grant order 0,1,2,0, with a 5-cycle GUARD between grants.
REQ-035 Timeout: TIMEOUT=16, req[1] held and no done -> err pulses once exactly 16 cycles after gnt[1] rises, gnt[1] drops, GUARD follows, then req[1] is re-granted.
REQ-036 Done/timeout collision: done[2] on the watchdog terminal cycle -> err stays 0, normal release.
REQ-037 Withdraw and foreign done: in GRANT for 0, done[1] pulse -> ignored; req[0] drops -> release to GUARD.
REQ-038 Reset mid-GRANT: rst=1 for 1 cycle while gnt=3'b100 -> gnt=0, cs_n=1 next cycle; after release with req=3'b110 -> gnt=3'b010.
